fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; the producer end of the decode/control interface.
//  Holds the PC and issues pipelined word reads to instruction memory.
//  Buffers returned instructions in a small FIFO and presents them to the
//  control_unit decode stage over a valid/ready handshake.
//  Consumes the PCSrc redirect and branch/jump target to squash the wrong path.
// PARAMETERS
//  ADDR_WIDTH  32  PC / imem address width
//  DATA_WIDTH  32  instruction width
//  FIFO_DEPTH  4   instruction buffer entries (power of 2, >=2); also the max in-flight reads
//  RESET_PC    0   PC loaded on reset
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           synchronous, active-high reset
//  PCSrc           in   1           redirect request from the branch-resolution stage
//  PCTarget        in   ADDR_WIDTH  redirect address; bits [1:0] are ignored and treated as 0
//  imem_req_valid  out  1           read request valid
//  imem_req_ready  in   1           memory accepts the request
//  imem_req_addr   out  ADDR_WIDTH  word-aligned read address
//  imem_rsp_valid  in   1           read data returned; in order, >=1 cycle after accept, no back-pressure
//  imem_rsp_data   in   DATA_WIDTH  returned instruction
//  instr_valid     out  1           FIFO head valid toward decode
//  instr_ready     in   1           decode consumes the head
//  instr           out  DATA_WIDTH  instruction at the head
//  instr_pc        out  ADDR_WIDTH  PC of the head instruction
//  instr_pc_plus4  out  ADDR_WIDTH  instr_pc+4, modulo 2^ADDR_WIDTH
// BEHAVIOUR
//  Reset:
//   - pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
//   - imem_req_valid=0, instr_valid=0, instr/instr_pc/instr_pc_plus4=0.
//  Issue:
//   - imem_req_valid = !rst & !PCSrc & (outstanding+fifo_count < FIFO_DEPTH).
//   - imem_req_addr = pc.
//   - On handshake: pc <= pc+4 (wraps modulo 2^ADDR_WIDTH); outstanding++.
//  Credit rule:
//   - Every accepted, non-discarded read is guaranteed a FIFO slot.
//   - A response is never dropped for lack of space.
//  Response, discard!=0:
//   - Data is dropped; discard--; outstanding--.
//  Response, discard==0:
//   - Push {pc_of_req, data}; outstanding--.
//   - PC tag comes from an internal in-flight PC queue of FIFO_DEPTH entries.
//  Output:
//   - FIFO is first-word-fall-through; instr_valid = !empty.
//   - Pop on instr_valid & instr_ready.
//  Latency:
//   - A response at edge N is visible at instr_valid after edge N (registered FIFO write).
//   - Push and pop in the same cycle are allowed when full or empty: count unchanged on full; no bypass on empty.
//  Redirect (PCSrc=1 in cycle N):
//   - imem_req_valid forced 0 in cycle N.
//   - At edge N: pc <= {PCTarget[AW-1:2],2'b00}; FIFO cleared; in-flight PC queue cleared.
//   - At edge N: discard <= outstanding - (imem_rsp_valid ? 1 : 0).
//   - A response arriving in cycle N is itself dropped.
//   - A pop in cycle N has no effect beyond the flush (decode is squashed externally).
//   - First target request is issued in cycle N+1.
//  Back-to-back redirects: the latest target wins; discard recomputed from current outstanding.
//  Redirect with nothing outstanding: discard=0; target fetched at N+1.
//  Reset mid-operation:
//   - All state returns to reset values.
//   - Imem shares rst and drops in-flight reads; no discard carry-over.
//  Counters:
//   - outstanding and discard are $clog2(FIFO_DEPTH)+1 bits.
//   - Overflow and underflow are assertion errors.
// STRUCTURE
//  Package fetch_pkg:
//   - fetch_entry_t struct {pc, instr}.
//   - RESET_PC default constant.
//   - NOP_INSTR = 32'h0000_0013.
//  Sub-module fetch_fifo:
//   - Parameterised sync FIFO of fetch_entry_t with flush, full/empty, count.
//   - Used for both the instruction buffer and the in-flight PC queue.
// TESTING
//  1. Reset, instr_ready=1, 1-cycle memory -> addrs 0,4,8,... issued every cycle; instr_pc tracks; instr_pc_plus4 = instr_pc+4.
//  2. instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; FIFO full; no data lost on release.
//  3. 3-cycle memory latency, 3 reads outstanding, PCSrc=1 with PCTarget=0x103 -> 3 responses dropped; next request addr=0x100; first instr_pc=0x100.
//  4. PCSrc pulsed two consecutive cycles (targets 0x40 then 0x80) -> no fetch from 0x40; first delivered instr_pc=0x80.
//  5. pc=0xFFFF_FFFC, issue two reads -> addrs 0xFFFFFFFC then 0x0; instr_pc_plus4 of first entry = 0x0.
//  6. rst asserted with FIFO full and 2 reads outstanding -> next cycle instr_valid=0, imem_req_valid=0; after release, first addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;

  localparam logic [FETCH_AW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [FETCH_DW-1:0] NOP_INSTR        = 32'h0000_0013;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// The element type is a parameter so the same block serves as the
// instruction buffer and as the queue of PCs for reads still in flight.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  // A pop on an empty FIFO is ignored, so a push into an empty FIFO is never
  // bypassed to the head; a push into a full FIFO is legal only with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define validity,
  // which keeps the array a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // A push that cannot be stored means the caller's credit accounting broke.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !do_push))
        else $error("fetch_fifo: push while full without pop");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues pipelined word reads, buffers
// returned instructions with their PCs and hands them to decode over a
// valid/ready handshake. A redirect squashes everything on the wrong path.
// The buffered entry type takes its field widths from fetch_pkg, so
// ADDR_WIDTH/DATA_WIDTH are expected to match FETCH_AW/FETCH_DW.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_AW,
  parameter int                    DATA_WIDTH = FETCH_DW,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         outstanding;   // all reads accepted but not yet answered
  logic [CW-1:0]         discard;       // leading responses that belong to a squashed path

  logic                  req_fire;
  logic                  rsp_keep;
  logic [CW:0]           credit_used;

  fetch_entry_t          buf_push_data;
  fetch_entry_t          buf_head;
  logic                  buf_pop;
  logic                  buf_full;
  logic                  buf_empty;
  logic [CW-1:0]         buf_count;

  logic [ADDR_WIDTH-1:0] pcq_head;
  logic                  pcq_full;
  logic                  pcq_empty;
  logic [CW-1:0]         pcq_count;

  // Credits: every accepted read already owns a buffer slot, so a response
  // can always be written and the memory never needs back-pressure.
  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = !rst && !PCSrc && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when it is on the current path and not in a redirect cycle.
  assign rsp_keep       = imem_rsp_valid && !PCSrc && (discard == '0);
  assign buf_push_data  = '{pc: pcq_head, instr: imem_rsp_data};
  assign instr_valid    = !buf_empty;
  assign buf_pop        = instr_valid && instr_ready;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrc),
    .push      (rsp_keep),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // PCs of kept in-flight reads, in issue order, used to tag each response.
  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (logic [ADDR_WIDTH-1:0])
  ) u_pcq (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrc),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  // Head presentation toward decode; fields read as zero while the buffer is empty.
  // NOTE: every output gets a default before the conditional so no latch is inferred.
  always_comb begin
    instr          = '0;
    instr_pc       = '0;
    instr_pc_plus4 = '0;
    if (instr_valid) begin
      instr          = buf_head.instr;
      instr_pc       = buf_head.pc;
      instr_pc_plus4 = buf_head.pc + ADDR_WIDTH'(4);
    end
  end

  // PC, in-flight and discard bookkeeping; a redirect overrides sequential fetch.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (PCSrc) begin
        pc      <= PCTarget & ~ADDR_WIDTH'(3);
        discard <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + ADDR_WIDTH'(4);
        if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  // Protocol and credit invariants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (outstanding == '0)))
        else $error("fetch_unit: response with no read outstanding");
      assert (!(req_fire && (outstanding == CW'(FIFO_DEPTH))))
        else $error("fetch_unit: outstanding counter overflow");
      assert (!(req_fire && pcq_full))
        else $error("fetch_unit: in-flight PC queue overflow");
      assert (!(rsp_keep && pcq_empty))
        else $error("fetch_unit: kept response without a PC tag");
      assert (!(rsp_keep && buf_full && !buf_pop))
        else $error("fetch_unit: response without a buffer slot");
      assert (pcq_count == outstanding - discard)
        else $error("fetch_unit: in-flight PC queue out of step with counters");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory with
// configurable latency, a delivery scoreboard fed with the expected PC stream
// whenever the fetch path is (re)started, and directed timing checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int             AW     = 32;
  localparam int             DW     = 32;
  localparam int             DEPTH  = 4;
  localparam logic [AW-1:0]  RST_PC = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          PCSrc;
  logic [AW-1:0] PCTarget;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] instr_pc_plus4;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  int            n_pass  = 0;
  int            n_fail  = 0;
  int            n_total = 0;
  int            n_deliv = 0;
  int            mem_lat = 1;
  int            cyc     = 0;
  logic [AW-1:0] exp_q     [$];
  logic [AW-1:0] acc_addr  [$];
  int            acc_cyc   [$];
  logic [AW-1:0] pend_addr [$];
  int            pend_due  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: distinct per address and never zero at address 0.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected delivery stream restarts from 'start' after a reset or redirect.
  task automatic push_stream(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_deliv(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_deliv < target; i++) @(negedge clk);
    check(tag, 32'(n_deliv >= target), 32'd1);
  endtask

  // Instruction memory: accepts every offered read, answers in order after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + mem_lat);
          acc_addr.push_back(imem_req_addr);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  // Delivery scoreboard; a handshake during reset or redirect is squashed by decode.
  initial begin : monitor
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !PCSrc && instr_valid && instr_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          check("sb_underrun", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_instr", instr, mem_word(e));
          check("sb_pc_plus4", instr_pc_plus4, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int b;
    int d;

    // Reset state, then 1-cycle memory with decode always ready.
    rst            = 1'b1;
    PCSrc          = 1'b0;
    PCTarget       = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_lat        = 1;
    push_stream(RST_PC);
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_instr_pc_plus4", instr_pc_plus4, 32'd0);

    rst = 1'b0;
    b   = acc_addr.size();
    d   = n_deliv;
    repeat (12) @(negedge clk);
    check("t1_nacc", 32'(acc_addr.size() - b), 32'd12);
    for (int i = 0; i < 4; i++) check("t1_addr", acc_addr[b + i], RST_PC + 32'(4 * i));
    check("t1_back_to_back", 32'(acc_cyc[b + 7] - acc_cyc[b]), 32'd7);
    wait_deliv("t1_deliv", d + 8, 20);

    // Decode stalled: exactly DEPTH reads, then issue stops; nothing lost on release.
    rst         = 1'b1;
    instr_ready = 1'b0;
    push_stream(RST_PC);
    @(negedge clk);
    rst = 1'b0;
    b   = acc_addr.size();
    d   = n_deliv;
    repeat (10) @(negedge clk);
    check("t2_nacc", 32'(acc_addr.size() - b), 32'(DEPTH));
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_instr_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, RST_PC);
    instr_ready = 1'b1;
    wait_deliv("t2_deliv", d + 8, 30);

    // 3-cycle memory, redirect with 3 reads outstanding to an unaligned target.
    rst     = 1'b1;
    mem_lat = 3;
    push_stream(RST_PC);
    @(negedge clk);
    rst = 1'b0;
    b   = acc_addr.size();
    repeat (3) @(negedge clk);
    check("t3_nacc_before", 32'(acc_addr.size() - b), 32'd3);
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0103;
    push_stream(32'h0000_0100);
    #2;
    check("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    PCSrc = 1'b0;
    #2;
    check("t3_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h0000_0100);
    check("t3_first_acc", acc_addr[b + 3], 32'h0000_0100);
    d = n_deliv;
    wait_deliv("t3_deliv", d + 6, 40);

    // Back-to-back redirects: the first target is never fetched.
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0040;
    push_stream(32'h0000_0040);
    b = acc_addr.size();
    @(negedge clk);
    PCTarget = 32'h0000_0080;
    push_stream(32'h0000_0080);
    @(negedge clk);
    PCSrc = 1'b0;
    #2;
    check("t4_req_addr", imem_req_addr, 32'h0000_0080);
    check("t4_nacc", 32'(acc_addr.size() - b), 32'd1);
    check("t4_first_acc", acc_addr[b], 32'h0000_0080);
    d = n_deliv;
    wait_deliv("t4_deliv", d + 6, 40);

    // PC wrap at the top of the address space.
    PCSrc    = 1'b1;
    PCTarget = 32'hFFFF_FFFE;
    push_stream(32'hFFFF_FFFC);
    b = acc_addr.size();
    @(negedge clk);
    PCSrc = 1'b0;
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    check("t5_head_valid", 32'(instr_valid), 32'd1);
    check("t5_head_pc", instr_pc, 32'hFFFF_FFFC);
    check("t5_head_pc_plus4", instr_pc_plus4, 32'h0000_0000);
    check("t5_nacc", 32'(acc_addr.size() - b >= 2), 32'd1);
    check("t5_acc0", acc_addr[b], 32'hFFFF_FFFC);
    check("t5_acc1", acc_addr[b + 1], 32'h0000_0000);
    d = n_deliv;
    wait_deliv("t5_deliv", d + 4, 30);

    // Reset while instructions are buffered and reads are in flight.
    rst         = 1'b1;
    instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b   = acc_addr.size();
    repeat (5) @(negedge clk);
    check("t6_nacc", 32'(acc_addr.size() - b), 32'd4);
    check("t6_buffered", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    push_stream(RST_PC);
    @(negedge clk);
    check("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;
    b   = acc_addr.size();
    #2;
    check("t6_req_valid", 32'(imem_req_valid), 32'd1);
    check("t6_req_addr", imem_req_addr, RST_PC);
    instr_ready = 1'b1;
    d = n_deliv;
    wait_deliv("t6_deliv", d + 6, 40);
    check("t6_first_acc", acc_addr[b], RST_PC);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
